prediction_metadata_queue: RTL

Parametrised FIFO that carries branch-prediction metadata from the branch prediction controller to the PD-stage boundary. Every fetch the controller issues produces one entry, and the IF stage consumes an entry for each instruction it retires to PD. Because each entry is tagged with its fetch PC, metadata stays correct across stalls, spanning instructions and multiple in-flight fetches. The block supersedes the single-entry save/restore tracking scheme.

---
 rtl/prediction_metadata_queue.sv | 124 ++++++++++++
 1 files changed

// File: rtl/prediction_metadata_queue.sv
// Circular FIFO of branch-prediction metadata, tagged with the fetch PC so the
// head prediction is only released to PD when it belongs to the consumed instruction.
module prediction_metadata_queue #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned META_W = 2
) (
  input  logic                       i_clk,
  input  logic                       i_reset_n,
  input  logic                       i_flush,
  input  logic                       i_push,
  input  logic [XLEN-1:0]            i_push_pc,
  input  logic                       i_push_hit,
  input  logic                       i_push_taken,
  input  logic [XLEN-1:0]            i_push_target,
  input  logic [META_W-1:0]          i_push_meta,
  output logic                       o_push_ready,
  input  logic                       i_pop,
  input  logic [XLEN-1:0]            i_consume_pc,
  input  logic                       i_sel_nop,
  output logic                       o_head_valid,
  output logic                       o_btb_hit,
  output logic                       o_btb_predicted_taken,
  output logic [XLEN-1:0]            o_btb_predicted_target,
  output logic [META_W-1:0]          o_btb_meta,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_overflow,
  output logic                       o_tag_mismatch
);

  localparam int unsigned PtrW   = $clog2(DEPTH);
  localparam int unsigned CntW   = $clog2(DEPTH+1);
  localparam int unsigned EntryW = (XLEN - 1) + 2 + XLEN + META_W;

  logic [EntryW-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              mismatch_q, mismatch_d;

  logic              full, push_acc, pop_acc, match;
  logic [EntryW-1:0] head, push_entry;
  logic [XLEN-2:0]   head_pc;
  logic              head_hit, head_taken;
  logic [XLEN-1:0]   head_target;
  logic [META_W-1:0] head_meta;

  // Bit 0 of a PC never distinguishes entries; tags compare halfword-aligned addresses.
  logic unused_pc_lsb;
  assign unused_pc_lsb = i_push_pc[0] ^ i_consume_pc[0];

  assign push_entry = {i_push_pc[XLEN-1:1], i_push_hit, i_push_taken, i_push_target, i_push_meta};
  assign head       = mem_q[rd_ptr_q];
  assign head_meta   = head[META_W-1:0];
  assign head_target = head[META_W +: XLEN];
  assign head_taken  = head[META_W + XLEN];
  assign head_hit    = head[META_W + XLEN + 1];
  assign head_pc     = head[META_W + XLEN + 2 +: XLEN - 1];

  always_comb begin
    full         = (count_q == CntW'(DEPTH));
    o_head_valid = (count_q != '0);
    o_push_ready = !full;
    o_count      = count_q;
    o_overflow   = overflow_q;
    o_tag_mismatch = mismatch_q;

    pop_acc  = i_pop && o_head_valid && !i_flush;
    push_acc = i_push && (!full || pop_acc) && !i_flush;
    match    = o_head_valid && (head_pc == i_consume_pc[XLEN-1:1]);

    o_btb_hit              = 1'b0;
    o_btb_predicted_taken  = 1'b0;
    o_btb_predicted_target = '0;
    o_btb_meta             = '0;
    if (match && !i_sel_nop) begin
      o_btb_hit              = head_hit;
      o_btb_predicted_taken  = head_taken;
      o_btb_predicted_target = head_target;
      o_btb_meta             = head_meta;
    end
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = i_push && full && !pop_acc && !i_flush;
    mismatch_d = mismatch_q || (pop_acc && !i_sel_nop && !match);
    if (i_flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      mismatch_d = 1'b0;
    end else begin
      if (push_acc) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop_acc)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      count_d = count_q + CntW'(push_acc) - CntW'(pop_acc);
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      mismatch_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      mismatch_q <= mismatch_d;
    end
  end

  // Payload storage needs no reset: every read is qualified by the occupancy count.
  always_ff @(posedge i_clk) begin
    if (push_acc) mem_q[wr_ptr_q] <= push_entry;
  end

endmodule
